// File: rtl/nes_pad_reader_if.sv
// Shared NES controller bus: one latch and one shift clock fanned out to both
// pads, plus a serial data return line from each pad.
interface nes_pad_reader_if;
  logic [1:0] pad_data;   // [0] = pad 1, [1] = pad 2, active-low
  logic       pad_latch;
  logic       pad_clk;

  modport master (
    input  pad_data,
    output pad_latch,
    output pad_clk
  );

  modport slave (
    output pad_data,
    input  pad_latch,
    input  pad_clk
  );
endinterface

// File: rtl/nes_pad_reader.sv
// Polls two NES controllers at a fixed rate over a shared latch/clock bus and
// publishes the decoded button state atomically once per completed frame.
module nes_pad_reader #(
  parameter int POLL_DIV  = 833333,
  parameter int PULSE_CYC = 300
) (
  input  logic                    clk,
  input  logic                    rst,
  nes_pad_reader_if.master        pad,
  output logic [3:0]              button,
  output logic [7:0]              pad_state_p1,
  output logic [7:0]              pad_state_p2,
  output logic                    frame_valid
);

  localparam int CW = $clog2(POLL_DIV);
  localparam int PW = $clog2(2 * PULSE_CYC);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_DIV - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * PULSE_CYC - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(PULSE_CYC - 1);

  typedef enum logic [2:0] {IDLE, LATCH, BIT0, CLK_HI, CLK_LO, UPDATE} state_t;

  // Conflicting Up+Down cancels to neither direction.
  function automatic logic [1:0] dir_bits(input logic [7:0] s);
    return {s[5] & ~s[4], s[4] & ~s[5]};
  endfunction

  logic [1:0]    sync1_q, sync2_q;
  logic [CW-1:0] poll_q, poll_d;
  logic          tick_q, tick_d;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh1_q, sh1_d, sh2_q, sh2_d;
  logic          latch_q, latch_d;
  logic          pclk_q, pclk_d;
  logic          fv_q, fv_d;
  logic [7:0]    p1_q, p1_d, p2_q, p2_d;
  logic [3:0]    btn_q, btn_d;
  logic          phase_last;

  // Synchroniser resets to "released" (line high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= pad.pad_data;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + CW'(1);
    tick_d = (poll_q == POLL_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      poll_q  <= '0;
      tick_q  <= 1'b0;
      phase_q <= '0;
      idx_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      fv_q    <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      fv_q    <= fv_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      btn_q   <= btn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + PW'(1);
    idx_d      = idx_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    phase_last = (state_q == LATCH) ? (phase_q == LATCH_LAST) : (phase_q == HALF_LAST);

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (tick_q) state_d = LATCH;
      end
      LATCH: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = BIT0;
        end
      end
      BIT0: begin
        if (phase_last) begin
          sh1_d[0] = ~sync2_q[0];
          sh2_d[0] = ~sync2_q[1];
          idx_d    = 3'd1;
          phase_d  = '0;
          state_d  = CLK_HI;
        end
      end
      CLK_HI: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = CLK_LO;
        end
      end
      CLK_LO: begin
        if (phase_last) begin
          sh1_d[idx_q] = ~sync2_q[0];
          sh2_d[idx_q] = ~sync2_q[1];
          phase_d      = '0;
          if (idx_q == 3'd7) begin
            state_d = UPDATE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = CLK_HI;
          end
        end
      end
      UPDATE: begin
        phase_d = '0;
        state_d = IDLE;
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Bus and result outputs are registered from the next state so they line
  // up exactly with the state they belong to and never glitch.
  always_comb begin
    latch_d = (state_d == LATCH);
    pclk_d  = (state_d == CLK_HI);
    fv_d    = (state_d == UPDATE);
    p1_d    = p1_q;
    p2_d    = p2_q;
    btn_d   = btn_q;
    if (state_d == UPDATE) begin
      p1_d  = sh1_d;
      p2_d  = sh2_d;
      btn_d = {dir_bits(sh2_d), dir_bits(sh1_d)};
    end
  end

  assign pad.pad_latch    = latch_q;
  assign pad.pad_clk      = pclk_q;
  assign frame_valid      = fv_q;
  assign pad_state_p1     = p1_q;
  assign pad_state_p2     = p2_q;
  assign button           = btn_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: two behavioural shift-register pads, a queue of
// expected frames, and one task per scenario.
module tb_nes_pad_reader;
  localparam int POLL_DIV  = 100;
  localparam int PULSE_CYC = 4;
  localparam int FV_OFS    = 17 * PULSE_CYC;   // first latch-high cycle to frame_valid

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] button;
  logic [7:0] pad_state_p1, pad_state_p2;
  logic       frame_valid;

  nes_pad_reader_if pad_if ();

  nes_pad_reader #(.POLL_DIV(POLL_DIV), .PULSE_CYC(PULSE_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pad          (pad_if),
    .button       (button),
    .pad_state_p1 (pad_state_p1),
    .pad_state_p2 (pad_state_p2),
    .frame_valid  (frame_valid)
  );

  always #5 clk = ~clk;

  // Behavioural 4021-style pads: parallel load while latched, shift on pad_clk rise.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic       disc1 = 1'b0, disc2 = 1'b0;
  logic [7:0] sr1 = 8'hFF, sr2 = 8'hFF;
  logic       clk_prev = 1'b0;

  always @(posedge clk) begin
    clk_prev <= pad_if.pad_clk;
    if (pad_if.pad_latch) begin
      sr1 <= ~btn1;
      sr2 <= ~btn2;
    end else if (pad_if.pad_clk && !clk_prev) begin
      sr1 <= {1'b1, sr1[7:1]};
      sr2 <= {1'b1, sr2[7:1]};
    end
  end

  assign pad_if.pad_data = {disc2 ? 1'b1 : sr2[0], disc1 ? 1'b1 : sr1[0]};

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] sb[$];   // {p1, p2, button}

  function automatic logic [19:0] expect_of(input logic [7:0] b1, input logic [7:0] b2,
                                            input logic d1, input logic d2);
    logic [7:0] s1, s2;
    logic [3:0] b;
    s1 = d1 ? 8'h00 : b1;
    s2 = d2 ? 8'h00 : b2;
    b  = {s2[5] & ~s2[4], s2[4] & ~s2[5], s1[5] & ~s1[4], s1[4] & ~s1[5]};
    return {s1, s2, b};
  endfunction

  task automatic push_exp(input logic [7:0] b1, input logic [7:0] b2,
                          input logic d1, input logic d2);
    btn1  = b1;
    btn2  = b2;
    disc1 = d1;
    disc2 = d2;
    sb.push_back(expect_of(b1, b2, d1, d2));
  endtask

  task automatic wait_fv(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic [19:0] observed();
    return {pad_state_p1, pad_state_p2, button};
  endfunction

  task automatic test_reset;
    int n;
    logic [19:0] exp_v, got;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    got = {4'h0, pad_if.pad_latch, pad_if.pad_clk, frame_valid, 1'b0, button, pad_state_p1};
    if (got !== 20'h0 || pad_state_p2 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: latch=%b clk=%b fv=%b btn=%b p1=%h p2=%h, required all 0",
               pad_if.pad_latch, pad_if.pad_clk, frame_valid, button, pad_state_p1, pad_state_p2);
    end
    push_exp(8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (pad_if.pad_latch) begin
        n = i;
        break;
      end
    end
    vectors++;
    if (n != POLL_DIV + 1) begin
      miscompares++;
      $display("FAIL first_latch: latch rose %0d cycles after reset release, required %0d", n, POLL_DIV + 1);
    end
    wait_fv(200, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL idle_frame: got %h (wait %0d), required %h", got, n, exp_v);
    end
  endtask

  task automatic test_up_p1;
    int n;
    logic [19:0] exp_v, got;
    push_exp(8'h10, 8'h00, 1'b0, 1'b0);
    wait_fv(250, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v || exp_v !== {8'h10, 8'h00, 4'b0001}) begin
      miscompares++;
      $display("FAIL up_p1: got %h (wait %0d), required %h", got, n, {8'h10, 8'h00, 4'b0001});
    end
    @(negedge clk);
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fv_pulse_width: frame_valid=%b one cycle after pulse, required 0", frame_valid);
    end
  endtask

  task automatic test_down_p2;
    int n;
    logic [19:0] exp_v, got;
    push_exp(8'h00, 8'h20, 1'b0, 1'b0);
    wait_fv(250, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL down_p2: got %h (wait %0d), required %h", got, n, exp_v);
    end
  endtask

  task automatic test_up_down_p1;
    int n;
    logic [19:0] exp_v, got;
    push_exp(8'h30, 8'h00, 1'b0, 1'b0);
    wait_fv(250, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL up_down_p1: got %h (wait %0d), required %h", got, n, exp_v);
    end
  endtask

  task automatic test_random;
    int n;
    logic [19:0] exp_v, got;
    for (int r = 0; r < 4; r++) begin
      push_exp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      wait_fv(250, n);
      vectors++;
      exp_v = sb.pop_front();
      got   = observed();
      if (n < 0 || got !== exp_v) begin
        miscompares++;
        $display("FAIL random_%0d: got %h (wait %0d), required %h", r, got, n, exp_v);
      end
    end
  endtask

  task automatic test_disconnected;
    int n;
    logic [19:0] exp_v, got;
    push_exp(8'hFF, 8'h03, 1'b1, 1'b0);
    wait_fv(250, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL disc_p1: got %h (wait %0d), required %h", got, n, exp_v);
    end
    push_exp(8'h11, 8'hFF, 1'b0, 1'b1);
    wait_fv(250, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL disc_p2: got %h (wait %0d), required %h", got, n, exp_v);
    end
  endtask

  task automatic test_waveform;
    int n, latch_cyc, pulses, bad_run, run, fv_at;
    logic prev_clk;
    logic [19:0] exp_v, got;
    push_exp(8'h81, 8'h21, 1'b0, 1'b0);
    n = -1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (pad_if.pad_latch) begin
        n = i;
        break;
      end
    end
    latch_cyc = 0; pulses = 0; bad_run = 0; run = 0; fv_at = -1; prev_clk = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (pad_if.pad_latch) latch_cyc++;
      if (pad_if.pad_clk) begin
        if (!prev_clk) pulses++;
        run++;
      end else begin
        if (prev_clk && run != PULSE_CYC) bad_run++;
        run = 0;
      end
      prev_clk = pad_if.pad_clk;
      if (frame_valid) begin
        fv_at = k;
        break;
      end
    end
    vectors++;
    if (n < 0 || latch_cyc != 2 * PULSE_CYC) begin
      miscompares++;
      $display("FAIL latch_width: latch high %0d cycles, required %0d", latch_cyc, 2 * PULSE_CYC);
    end
    vectors++;
    if (pulses != 7 || bad_run != 0) begin
      miscompares++;
      $display("FAIL clk_pulses: %0d pulses, %0d of wrong width, required 7 pulses of %0d cycles",
               pulses, bad_run, PULSE_CYC);
    end
    vectors++;
    if (fv_at != FV_OFS) begin
      miscompares++;
      $display("FAIL fv_timing: frame_valid %0d cycles after latch rise, required %0d", fv_at, FV_OFS);
    end
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (fv_at < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL waveform_data: got %h, required %h", got, exp_v);
    end
    n = -1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (pad_if.pad_latch) begin
        n = i;
        break;
      end
    end
    vectors++;
    if (n != POLL_DIV - FV_OFS) begin
      miscompares++;
      $display("FAIL poll_period: next latch %0d cycles after frame_valid, required %0d", n, POLL_DIV - FV_OFS);
    end
    sb.push_back(exp_v);
    wait_fv(150, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL waveform_repeat: got %h (wait %0d), required %h", got, n, exp_v);
    end
  endtask

  task automatic test_hold_until_update;
    int n, bad;
    logic [19:0] exp_v, got;
    push_exp(8'h10, 8'h00, 1'b0, 1'b0);
    wait_fv(250, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL hold_setup: got %h (wait %0d), required %h", got, n, exp_v);
    end
    push_exp(8'h00, 8'h00, 1'b0, 1'b0);
    bad = 0;
    n   = -1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        n = i;
        break;
      end
      if (button !== 4'b0001) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold_between: button left 0001 on %0d cycles before update, required 0", bad);
    end
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL hold_release: got %h (wait %0d), required %h", got, n, exp_v);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    logic [19:0] exp_v, got;
    push_exp(8'h10, 8'h00, 1'b0, 1'b0);
    wait_fv(250, n);
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL midrst_setup: got %h (wait %0d), required %h", got, n, exp_v);
    end
    n = -1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (pad_if.pad_clk) begin
        n = i;
        break;
      end
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (n < 0 || pad_if.pad_clk !== 1'b0 || button !== 4'b0000 || frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_force: pad_clk=%b button=%b fv=%b (clk wait %0d), required 0/0000/0",
               pad_if.pad_clk, button, frame_valid, n);
    end
    repeat (3) @(negedge clk);
    sb.push_back(expect_of(btn1, btn2, disc1, disc2));
    rst = 1'b1;
    wait_fv(400, n);
    vectors++;
    if (n != POLL_DIV + 1 + FV_OFS) begin
      miscompares++;
      $display("FAIL midrst_timing: first frame_valid %0d cycles after release, required %0d",
               n, POLL_DIV + 1 + FV_OFS);
    end
    vectors++;
    exp_v = sb.pop_front();
    got   = observed();
    if (n < 0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL midrst_data: got %h, required %h", got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_up_p1();
    test_down_p2();
    test_up_down_p1();
    test_random();
    test_disconnected();
    test_waveform();
    test_hold_until_update();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 SHALL have parameter POLL_DIV, default 833333, clk cycles between poll ticks (60 Hz at 50 MHz).
REQ-002 SHALL have parameter PULSE_CYC, default 300, clk cycles per protocol half-period (6 us at 50 MHz); legal range PULSE_CYC>=4 and POLL_DIV>17*PULSE_CYC+2.
REQ-003 clk  input  1  50 MHz system clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 pad_data  input  2  serial data from pad 1 [0] and pad 2 [1]; asynchronous, active-low (0 = pressed).
REQ-006 pad_latch  output  1  shared latch strobe to both pads.
REQ-007 pad_clk  output  1  shared shift clock to both pads; idles low.
REQ-008 button  output  4  {down_p2, up_p2, down_p1, up_p1}, active-high; drives the game engine button vector directly.
REQ-009 pad_state_p1  output  8  decoded pad 1 state, 1 = pressed; bits [0..7] = A, B, Select, Start, Up, Down, Left, Right.
REQ-010 pad_state_p2  output  8  pad 2 state, same bit map.
REQ-011 frame_valid  output  1  one-cycle pulse when outputs update.

Function
REQ-012 SHALL pass pad_data through a 2-flop synchroniser per bit; all sampling uses synchronised values.
REQ-013 SHALL run a free-running poll counter 0..POLL_DIV-1, emitting a one-cycle tick on wrap.
REQ-014 FSM states SHALL be IDLE, LATCH, BIT0, CLK_HI, CLK_LO, UPDATE, with one shared phase counter and a 3-bit bit index.
REQ-015 IDLE -> LATCH on tick; tick in any other state SHALL be ignored (no queuing).
REQ-016 LATCH: pad_latch=1 for exactly 2*PULSE_CYC cycles, then -> BIT0.
REQ-017 BIT0: pad_latch=0, pad_clk=0 for PULSE_CYC cycles; sample both data lines on last cycle into shift position 0, then -> CLK_HI with index=1.
REQ-018 CLK_HI: pad_clk=1 for PULSE_CYC cycles, then -> CLK_LO.
REQ-019 CLK_LO: pad_clk=0 for PULSE_CYC cycles; sample on last cycle into position index; if index=7 -> UPDATE, else index+1 -> CLK_HI.
REQ-020 Exactly 7 pad_clk high pulses per frame; frame length 17*PULSE_CYC+1 cycles from the cycle after tick to end of UPDATE.
REQ-021 Sampled bits SHALL be inverted (active-low to active-high) at capture.
REQ-022 UPDATE (1 cycle): load pad_state_p1/p2 from shift registers, load button, pulse frame_valid=1, -> IDLE.
REQ-023 up_pX=Up&~Down, down_pX=Down&~Up; Up and Down both pressed SHALL give both 0.
REQ-024 Outputs SHALL hold between UPDATE cycles; partial frames never reach outputs.
REQ-025 Disconnected pad (line floating high via pull-up) SHALL decode as all released.

Reset
REQ-026 rst=0 SHALL immediately force pad_latch=0, pad_clk=0, button=0, pad_state_p1=0, pad_state_p2=0, frame_valid=0, FSM=IDLE, all counters and synchronisers to 0/released.
REQ-027 After rst release, first tick SHALL occur POLL_DIV cycles later; reset mid-frame aborts the frame with no output update.

Verification (PULSE_CYC=4, POLL_DIV=100)
REQ-028 Pad 1 drives 0 only in Up slot (bit 4), pad 2 idle -> pad_state_p1=8'h10, pad_state_p2=8'h00, button=4'b0001, single frame_valid pulse.
REQ-029 Pad 2 Down only (bit 5) -> pad_state_p2=8'h20, button=4'b1000.
REQ-030 Pad 1 Up+Down held -> pad_state_p1=8'h30, button[1:0]=2'b00.
REQ-031 Waveform check: pad_latch high exactly 8 cycles, 7 pad_clk pulses each 4 cycles high, frame_valid 69 cycles after tick.
REQ-032 rst asserted during CLK_HI with Up pressed -> pad_clk=0 and button=0 same cycle; no frame_valid until a full new frame completes.
REQ-033 Release Up after frame N sampled -> button stays 4'b0001 until UPDATE of frame N+1, then 4'b0000.
